// File: rtl/apb_arb_pkg.sv
// Shared types and helpers for the multi-requester APB master.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_e;

    // PPROT driven when the APB3 flavour is built (no protection info on the bus).
    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    // Width of the PADDR slice that selects a PSEL line; a single PSEL needs no slice.
    function automatic int sel_width(input int nsel);
        return (nsel <= 1) ? 0 : $clog2(nsel);
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
// Latency: combinational; the parent owns and advances the pointer.
// Backpressure: none; the grant is only a selection, the parent decides when to take it.
// Ports: req_i request vector, ptr_i highest-priority index,
//        gnt_o one-hot grant, gnt_idx_o grant index, any_o some request present.
module apb_rr_arbiter #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   gnt_idx_o,
    output logic            any_o
);

    int k;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        k         = 0;
        for (int off = 0; off < NREQ; off++) begin
            k = (int'(ptr_i) + off) % NREQ;
            if (!any_o && req_i[k]) begin
                any_o     = 1'b1;
                gnt_o[k]  = 1'b1;
                gnt_idx_o = IW'(k);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB3/APB4 bus among NREQ requesters: round-robin grant, PSEL decode, SETUP/ACCESS.
// Latency: grant in the request cycle, >=3 cycles to rsp_valid (IDLE grant, SETUP, ACCESS + PREADY waits).
// Backpressure: req_ready only in IDLE; PREADY low stretches ACCESS; rsp_valid is a pulse, never stalled.
// Ports: req_* per-requester packed request, rsp_* response routed to the owner, P* APB master side.
// Optional: define KVIPS_APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT PREADY-low cycles.
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter  int NREQ    = 2,
    parameter  int ADDR_W  = 32,
    parameter  int DATA_W  = 32,
    parameter  int NSEL    = 1,
    parameter  int SEL_LSB = 12,
    parameter  int APB4    = 1,
    parameter  int TIMEOUT = 256,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ-1:0]          req_write,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    input  logic [NREQ*STRB_W-1:0]   req_strb,
    input  logic [NREQ*3-1:0]        req_prot,
    output logic [NREQ-1:0]          rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [NSEL-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [DATA_W-1:0]        PWDATA,
    output logic [2:0]               PPROT,
    output logic [STRB_W-1:0]        PSTRB,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int IW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SEL_W = sel_width(NSEL);
    localparam int IDX_W = (SEL_W > 0) ? SEL_W : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [IW-1:0]       owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic [2:0]          prot_q;
    logic [NSEL-1:0]     sel_q;
    logic [NREQ-1:0]     rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [NREQ-1:0]     gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;
    logic                take;
    logic [ADDR_W-1:0]   win_addr;
    logic [IDX_W-1:0]    win_sel_idx;
    logic                dec_hit;
    logic [NSEL-1:0]     win_psel;
    logic [NREQ-1:0]     owner_oh;

    // Grants are only offered while the bus is free.
    apb_rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_i     (req_valid & {NREQ{state_q == IDLE}}),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_o     (gnt_any)
    );

    assign req_ready = gnt;
    assign win_addr  = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];

    if (SEL_W == 0) begin : g_one_sel
        assign win_sel_idx = '0;
    end else begin : g_sel
        assign win_sel_idx = win_addr[SEL_LSB +: SEL_W];
    end

    // Non-power-of-two NSEL leaves slice codes with no slave behind them.
    assign dec_hit  = int'(win_sel_idx) < NSEL;
    assign win_psel = dec_hit ? (NSEL'(1) << win_sel_idx) : '0;
    assign owner_oh = NREQ'(1) << owner_q;

`ifdef KVIPS_APB_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_q <= '0;
        end else if (state_q == ACCESS && !PREADY) begin
            tmo_q <= tmo_q + 1'b1;
        end
    end
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT != 0);
`endif

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        take        = 1'b0;
        rsp_vld_d   = '0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_any) begin
                    take    = 1'b1;
                    ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = dec_hit ? SETUP : ERR;
                    // Decode miss answers during the ERR cycle without touching the bus.
                    if (!dec_hit) begin
                        rsp_vld_d = gnt;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    state_d     = IDLE;
                    rsp_vld_d   = owner_oh;
                    rsp_rdata_d = write_q ? '0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end
`ifdef KVIPS_APB_ARB_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    state_d   = IDLE;
                    rsp_vld_d = owner_oh;
                    rsp_err_d = 1'b1;
                end
`endif
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= '0;
            sel_q       <= '0;
            rsp_vld_q   <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_vld_q   <= rsp_vld_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            if (take) begin
                owner_q <= gnt_idx;
                addr_q  <= win_addr;
                write_q <= req_write[gnt_idx];
                wdata_q <= req_wdata[int'(gnt_idx)*DATA_W +: DATA_W];
                strb_q  <= req_strb[int'(gnt_idx)*STRB_W +: STRB_W];
                prot_q  <= req_prot[int'(gnt_idx)*3 +: 3];
                sel_q   <= win_psel;
            end
        end
    end

    // Address/data registers only change on a grant, so they hold through IDLE.
    assign PSEL      = (state_q == SETUP || state_q == ACCESS) ? sel_q : '0;
    assign PENABLE   = (state_q == ACCESS);
    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign rsp_valid = rsp_vld_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    if (APB4 != 0) begin : g_apb4
        assign PPROT = prot_q;
        assign PSTRB = strb_q;
    end else begin : g_apb3
        assign PPROT = PPROT_DEFAULT;
        assign PSTRB = write_q ? {STRB_W{1'b1}} : '0;
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter (NREQ=2, NSEL=3, SEL_LSB=12, TIMEOUT=8).
// Expected responses are queued at grant time and popped when rsp_valid pulses.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
`define CHK(tag, obs, exp) chk(tag, 64'(obs), 64'(exp))

module tb_apb_master_arbiter;

    localparam int NREQ = 2;

    logic              PCLK = 1'b0;
    logic              PRESET;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*32-1:0] req_wdata;
    logic [NREQ*4-1:0] req_strb;
    logic [NREQ*3-1:0] req_prot;
    logic [NREQ-1:0]   rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [31:0]       PADDR;
    logic [2:0]        PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [2:0]        PPROT;
    logic [3:0]        PSTRB;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    apb_master_arbiter #(
        .NREQ(NREQ), .ADDR_W(32), .DATA_W(32), .NSEL(3), .SEL_LSB(12), .APB4(1), .TIMEOUT(8)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_strb(req_strb),
        .req_prot(req_prot), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PPROT(PPROT), .PSTRB(PSTRB),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    typedef struct {
        int          owner;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input int owner, input logic [31:0] rdata, input logic err);
        rsp_t e;
        e.owner = owner;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    // Called in the cycle a response is due.
    task automatic check_rsp();
        rsp_t e;
        `CHK("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            `CHK("rsp_valid", rsp_valid, 1 << e.owner);
            `CHK("rsp_rdata", rsp_rdata, e.rdata);
            `CHK("rsp_err", rsp_err, e.err);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] addr, input logic wr,
                           input logic [31:0] wdata, input logic [3:0] strb, input logic [2:0] prot);
        req_addr[r*32 +: 32] = addr;
        req_write[r]         = wr;
        req_wdata[r*32 +: 32] = wdata;
        req_strb[r*4 +: 4]   = strb;
        req_prot[r*3 +: 3]   = prot;
    endtask

    // One complete transfer; exp_sel==0 means the address should miss the decode.
    task automatic xfer(input int r, input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input int waits, input logic [31:0] rdata, input logic slverr,
                        input logic [2:0] exp_sel);
        @(negedge PCLK);
        set_req(r, addr, wr, wdata, 4'b0110, 3'b101);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        #1;
        `CHK("req_ready", req_ready, 1 << r);
        if (exp_sel == 3'b000) push_rsp(r, 32'h0, 1'b1);
        else                   push_rsp(r, wr ? 32'h0 : rdata, slverr);
        @(negedge PCLK);
        req_valid = '0;
        #1;
        if (exp_sel == 3'b000) begin
            `CHK("err_no_psel", PSEL, 3'b000);
            check_rsp();
        end else begin
            `CHK("setup_psel", PSEL, exp_sel);
            `CHK("setup_penable", PENABLE, 1'b0);
            `CHK("setup_paddr", PADDR, addr);
            `CHK("setup_pwrite", PWRITE, wr);
            `CHK("setup_pwdata", PWDATA, wdata);
            `CHK("setup_pstrb", PSTRB, 4'b0110);
            `CHK("setup_pprot", PPROT, 3'b101);
            for (int n = 0; n <= waits; n++) begin
                @(negedge PCLK);
                PREADY  = (n == waits);
                PRDATA  = (n == waits) ? rdata : 32'h5555_AAAA;
                PSLVERR = (n == waits) && slverr;
                #1;
                `CHK("access_penable", PENABLE, 1'b1);
                `CHK("access_psel", PSEL, exp_sel);
                `CHK("access_paddr", PADDR, addr);
                `CHK("access_pwdata", PWDATA, wdata);
                `CHK("access_no_rsp", rsp_valid, 2'b00);
            end
            @(negedge PCLK);
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            #1;
            `CHK("done_psel", PSEL, 3'b000);
            `CHK("done_penable", PENABLE, 1'b0);
            `CHK("idle_paddr_hold", PADDR, addr);
            check_rsp();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_write = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        repeat (2) @(negedge PCLK);
        #1;
        `CHK("rst_psel", PSEL, 3'b000);
        `CHK("rst_penable", PENABLE, 1'b0);
        `CHK("rst_rsp_valid", rsp_valid, 2'b00);
        `CHK("rst_req_ready", req_ready, 2'b00);
        `CHK("rst_paddr", PADDR, 32'h0);
        `CHK("rst_pstrb", PSTRB, 4'h0);
        `CHK("rst_rsp_err", rsp_err, 1'b0);
        PRESET = 1'b0;

        // Single write, no wait states; PRDATA must not leak into a write response.
        xfer(0, 32'h0000_0010, 1'b1, 32'hA5A5_0001, 0, 32'h1234_5678, 1'b0, 3'b001);
        // Read with three PREADY-low cycles.
        xfer(1, 32'h0000_1004, 1'b0, 32'h0000_0000, 3, 32'hDEAD_BEEF, 1'b0, 3'b010);

        // Both requesters hold valid: grants must alternate starting from 0.
        set_req(0, 32'h0000_0100, 1'b1, 32'h0000_0011, 4'hF, 3'b000);
        set_req(1, 32'h0000_1100, 1'b1, 32'h0000_0022, 4'hF, 3'b000);
        @(negedge PCLK);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_cmp++;
            if (req_ready !== 2'(1 << (k % 2))) begin
                n_bad++;
                $error("FAIL rr_grant: observed=%0h expected=%0h", req_ready, 2'(1 << (k % 2)));
            end
            push_rsp(k % 2, 32'h0, 1'b0);
            @(negedge PCLK);
            #1;
            n_cmp++;
            if (PADDR !== ((k % 2 == 0) ? 32'h0000_0100 : 32'h0000_1100)) begin
                n_bad++;
                $error("FAIL rr_paddr: observed=%0h expected=%0h", PADDR,
                       (k % 2 == 0) ? 32'h0000_0100 : 32'h0000_1100);
            end
            @(negedge PCLK);
            PREADY = 1'b1;
            @(negedge PCLK);
            PREADY = 1'b0;
            if (k == 3) req_valid = '0;
            #1;
            check_rsp();
        end

        // Decode: slice code 3 has no slave, slice code 2 drives the top PSEL.
        xfer(0, 32'h0000_3000, 1'b0, 32'h0, 0, 32'hFFFF_FFFF, 1'b0, 3'b000);
        xfer(1, 32'h0000_2000, 1'b1, 32'hCAFE_0002, 1, 32'h0, 1'b0, 3'b100);
        // Slave errors, read and write.
        xfer(0, 32'h0000_0040, 1'b0, 32'h0, 0, 32'h0BAD_0BAD, 1'b1, 3'b001);
        xfer(1, 32'h0000_1040, 1'b1, 32'h7777_0000, 2, 32'h9999_9999, 1'b1, 3'b010);

        // Reset in ACCESS: bus drops at once and the transfer never answers.
        @(negedge PCLK);
        set_req(0, 32'h0000_0020, 1'b0, 32'h0, 4'hF, 3'b000);
        req_valid = 2'b01;
        @(negedge PCLK);
        req_valid = '0;
        @(negedge PCLK);
        #1;
        `CHK("prerst_penable", PENABLE, 1'b1);
        PRESET = 1'b1;
        #1;
        `CHK("midrst_psel", PSEL, 3'b000);
        `CHK("midrst_penable", PENABLE, 1'b0);
        @(negedge PCLK);
        PRESET = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge PCLK);
            #1;
            n_cmp++;
            if (rsp_valid !== 2'b00) begin
                n_bad++;
                $error("FAIL midrst_no_rsp: observed=%0h expected=0", rsp_valid);
            end
        end
        `CHK("sb_drained", sb.size(), 0);

`ifdef KVIPS_APB_ARB_TIMEOUT_EN
        // PREADY never rises: eight ACCESS cycles, then an error response.
        @(negedge PCLK);
        set_req(1, 32'h0000_1000, 1'b0, 32'h0, 4'hF, 3'b000);
        req_valid = 2'b10;
        #1;
        `CHK("tmo_grant", req_ready, 2'b10);
        push_rsp(1, 32'h0, 1'b1);
        @(negedge PCLK);
        req_valid = '0;
        PRDATA    = 32'h4444_4444;
        for (int n = 0; n < 8; n++) begin
            @(negedge PCLK);
            #1;
            `CHK("tmo_penable", PENABLE, 1'b1);
            `CHK("tmo_no_rsp", rsp_valid, 2'b00);
        end
        @(negedge PCLK);
        #1;
        `CHK("tmo_psel", PSEL, 3'b000);
        `CHK("tmo_penable_off", PENABLE, 1'b0);
        check_rsp();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Multi-requester APB3/APB4 master for RTL-side use; shares one APB bus (PADDR/PSEL[NSEL]/PENABLE/PWRITE/PWDATA/PPROT/PSTRB) between NREQ requesters.
- Round-robin arbitration, address-slice decode onto PSEL, SETUP/ACCESS sequencing with PREADY wait states, response routing back to the winner.
- Sits between internal register-access masters and the APB fabric that the apb_if monitor/slave VIP observes.

Parameters:
- NREQ, 2, number of requesters (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8); STRB_W = DATA_W/8
- NSEL, 1, number of PSEL lines
- SEL_LSB, 12, LSB of PADDR slice that selects PSEL index (slice width clog2(NSEL), 0 if NSEL=1)
- APB4, 1, 1: pass PPROT/PSTRB; 0: PPROT=0, PSTRB all-ones on writes, 0 on reads
- TIMEOUT, 256, PREADY-low cycle limit (optional feature only)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset
- req_valid  in  NREQ  request pending per requester
- req_ready  out  NREQ  one-cycle accept pulse to winner
- req_addr  in  NREQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_write  in  NREQ  1=write
- req_wdata  in  NREQ*DATA_W  packed write data
- req_strb  in  NREQ*STRB_W  packed byte strobes
- req_prot  in  NREQ*3  packed protection
- rsp_valid  out  NREQ  one-cycle completion pulse to owner
- rsp_rdata  out  DATA_W  read data (shared, valid with rsp_valid)
- rsp_err  out  1  PSLVERR / decode / timeout error (valid with rsp_valid)
- PADDR, PSEL[NSEL], PENABLE, PWRITE, PWDATA[DATA_W], PPROT[3], PSTRB[STRB_W]  out  APB request
- PRDATA[DATA_W], PREADY, PSLVERR  in  APB response

Behaviour:
- One clock PCLK; reset PRESET is asynchronous, active-high.
- Reset: all outputs 0, FSM=IDLE, round-robin pointer=0 (requester 0 highest priority first).
- FSM IDLE -> SETUP -> ACCESS -> IDLE; ERR state for decode miss.
- IDLE: if any req_valid, pick first valid at or after pointer (wrapping); same cycle req_ready[win]=1; request fields registered at the edge; pointer <- win+1 mod NREQ. Requester must hold fields stable while valid until its ready.
- Decode: idx = PADDR[SEL_LSB +: w]; idx >= NSEL -> ERR (no PSEL asserted); next cycle rsp_valid[win]=1, rsp_err=1, rsp_rdata=0; -> IDLE.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, address/control/PWDATA driven from registers -> ACCESS.
- ACCESS: PENABLE=1, all signals held; each edge with PREADY=0 stays; edge with PREADY=1: capture PRDATA (reads; 0 for writes) and PSLVERR, rsp_valid[win]=1 next cycle, PSEL/PENABLE deasserted -> IDLE.
- Minimum 3 cycles per transfer; PADDR/PWRITE/PWDATA hold last values in IDLE (PSEL=0).
- req_valid dropped after grant has no effect on the in-flight transfer.
- PRESET mid-transfer: bus returns to idle immediately, no rsp_valid issued.
- rsp_valid is never back-pressured; exactly one rsp_valid per req_ready.

Optional Feature:
- Macro KVIPS_APB_ARB_TIMEOUT_EN.
- Defined: counter clears on entering ACCESS, increments per PREADY-low cycle; at TIMEOUT, drop PSEL/PENABLE, rsp_valid with rsp_err=1, rsp_rdata=0, -> IDLE.
- Not defined: ACCESS waits indefinitely; no counter logic, TIMEOUT unused.

Decomposition:
- Package apb_arb_pkg: state enum (IDLE/SETUP/ACCESS/ERR), PPROT default constant, clog2-based SEL width helper.
- Sub-module apb_rr_arbiter (NREQ): req vector + pointer -> one-hot grant + index; combinational, pointer update in parent.

Test Plan:
- Single write req0 addr 0x0000_0010 data 0xA5A5_0001, PREADY=1 -> PSEL[0] SETUP 1 cycle, ACCESS 1 cycle, rsp_valid[0] pulse, rsp_err=0.
- Read with PREADY low 3 cycles, PRDATA=0xDEAD_BEEF -> ACCESS lasts 4 cycles, signals stable, rsp_rdata=0xDEAD_BEEF.
- req0 and req1 valid continuously, 4 transfers -> grant order 0,1,0,1.
- NSEL=3, SEL_LSB=12, addr 0x3000 -> no PSEL, rsp_err=1, rsp_rdata=0; addr 0x2000 -> PSEL=3'b100.
- PSLVERR=1 with PREADY -> rsp_err=1; PRESET asserted during ACCESS -> PSEL/PENABLE 0 at once, no rsp_valid.
- With KVIPS_APB_ARB_TIMEOUT_EN, TIMEOUT=8, PREADY held 0 -> after 8 ACCESS cycles rsp_err=1, bus idle.
